pkt_framer: RTL and testbench
=============================

Name: pkt_framer

Overview:
Upstream framing stage for the crc block. Consumes a byte stream from the ingress FIFO and hunts for a start-of-frame byte. Packs the payload bytes into one wide word, captures the 4-byte received CRC trailer, and fires the crc block. Compares the computed CRC against the trailer and reports a per-packet pass/fail status.

Parameters:
PAYLOAD_BYTES, 40, payload length in bytes; PAYLOAD_BYTES*8 must equal the crc block data width (320).
SOF_BYTE, 8'h7E, start-of-frame delimiter.
TIMEOUT_CYCLES, 256, inter-byte gap limit; used only with PKT_TIMEOUT_EN.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
in_data  in  8  ingress byte from FIFO
in_valid  in  1  in_data valid
in_ready  out  1  framer accepts a byte when in_valid && in_ready
crc_valid  out  1  one-cycle start pulse to the crc block
crc_data  out  PAYLOAD_BYTES*8  packed payload to the crc block; first byte in [MSB:MSB-7]
crc_result  in  32  computed CRC from the crc block
crc_done  in  1  crc_result valid, one-cycle pulse
pkt_done  out  1  one-cycle pulse, packet verdict valid
pkt_ok  out  1  1 = crc_result == rx_crc; valid when pkt_done
rx_crc  out  32  received trailer CRC, MSB byte first
err_cnt  out  16  saturating count of failed packets

Behaviour:
- Reset (async assert, sync deassert by the caller): state = IDLE. All outputs 0 except in_ready = 1. crc_data, rx_crc, err_cnt and byte counter cleared.
- A byte transfer occurs on a posedge with in_valid && in_ready.
- IDLE:
  - in_ready = 1.
  - A transfer of SOF_BYTE goes to PAYLOAD with byte_cnt = 0.
  - Any other byte is discarded and the block stays in IDLE.
- PAYLOAD:
  - in_ready = 1.
  - Each transfer shifts the byte in: crc_data <= {crc_data[W-9:0], in_data}.
  - byte_cnt increments on each transfer.
  - On the transfer that makes byte_cnt == PAYLOAD_BYTES, go to TRAILER with byte_cnt = 0.
  - An SOF_BYTE value inside the payload is data, not a resync.
- TRAILER:
  - in_ready = 1.
  - Each transfer shifts into rx_crc MSB-first.
  - After the 4th byte, go to CRC_WAIT and assert crc_valid for exactly that one following cycle.
- CRC_WAIT:
  - in_ready = 0.
  - crc_data and rx_crc are held stable.
  - On crc_done, go to REPORT.
  - crc_done seen in any other state is ignored.
- REPORT:
  - One cycle: pkt_done = 1, pkt_ok = (crc_result registered at crc_done == rx_crc).
  - If !pkt_ok, err_cnt increments, saturating at 16'hFFFF.
  - Next state is IDLE.
- Latency:
  - crc_valid rises 1 cycle after the last trailer byte is accepted.
  - pkt_done rises 1 cycle after crc_done.
- in_valid low in any state: no progress, state held.
- Reset mid-packet: partial packet dropped, no pkt_done, err_cnt cleared.
- pkt_ok = 0 and rx_crc holds its last value outside the pkt_done cycle.

Optional Feature:
PKT_TIMEOUT_EN:
- When defined, a gap counter runs in PAYLOAD and TRAILER.
  - Reset to 0 on each transfer; incremented otherwise.
  - When it reaches TIMEOUT_CYCLES, go to IDLE and emit pkt_done = 1, pkt_ok = 0 for one cycle; err_cnt increments.
  - crc_valid is not issued.
- When undefined, the framer waits indefinitely and the counter logic is absent.

Decomposition:
- Shared package pkt_pkg holds:
  - state enum (IDLE, PAYLOAD, TRAILER, CRC_WAIT, REPORT);
  - SOF_BYTE_DEF;
  - CRC_W = 32;
  - PKT_DATA_W = 320.
- One natural sub-module: pkt_shift_reg (byte-serial to parallel shifter with load-count output), instantiated once for the payload.
- The 32-bit trailer shift is inline.

Test Plan:
- Reset, then SOF, then 40 bytes 01 23 45 67 … 89 AB CD EF (the 320-bit vector 0123456789ABCDEF00112233…0123456789ABCDEF), then trailer 63 9A 97 21, with crc block attached → crc_data equals the vector; crc_valid pulses once; pkt_done with pkt_ok = 1; err_cnt = 0.
- Same payload, trailer 63 9A 97 20 → pkt_ok = 0, err_cnt = 1.
- Garbage bytes 00 FF 55 before SOF → ignored; packet still framed correctly; in_valid toggled randomly mid-payload gives the same result.
- Bytes presented during CRC_WAIT → in_ready = 0, no byte lost; the next packet starts only after pkt_done.
- rst_n pulsed low after 20 payload bytes → outputs at reset values immediately; a following full packet passes.
- With PKT_TIMEOUT_EN defined: stall 256 cycles after 10 payload bytes → pkt_done with pkt_ok = 0, no crc_valid, back to IDLE.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet framer and its shifter.
package pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    TRAILER,
    CRC_WAIT,
    REPORT
  } state_e;

  localparam logic [7:0] SOF_BYTE_DEF = 8'h7E;
  localparam int         CRC_W        = 32;
  localparam int         PKT_DATA_W   = 320;

endpackage

// File: rtl/pkt_framer_if.sv
// Framer bus: ingress byte stream, crc block request/response and verdict.
// The slave modport is the framer's view; master is the surrounding logic.
interface pkt_framer_if;
  import pkt_pkg::*;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  crc_valid;
  logic [PKT_DATA_W-1:0] crc_data;
  logic [CRC_W-1:0]      crc_result;
  logic                  crc_done;
  logic                  pkt_done;
  logic                  pkt_ok;
  logic [CRC_W-1:0]      rx_crc;
  logic [15:0]           err_cnt;

  modport slave (
    input  in_data, in_valid, crc_result, crc_done,
    output in_ready, crc_valid, crc_data, pkt_done, pkt_ok, rx_crc, err_cnt
  );

  modport master (
    output in_data, in_valid, crc_result, crc_done,
    input  in_ready, crc_valid, crc_data, pkt_done, pkt_ok, rx_crc, err_cnt
  );

endinterface

// File: rtl/pkt_shift_reg.sv
// Byte-serial to parallel shifter; newest byte enters at the LSB end so the
// first byte of a full load ends up in the top byte lane.
module pkt_shift_reg #(
  parameter  int N_BYTES = 40,
  localparam int W       = N_BYTES * 8,
  localparam int CW      = $clog2(N_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          shift_i,
  input  logic [7:0]    byte_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  data_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (shift_i) data_q <= {data_q[W-9:0], byte_i};
      // Clear has priority so the count restarts cleanly on the final byte.
      if (clr_i)        cnt_q <= '0;
      else if (shift_i) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pkt_framer.sv
// SOF-hunting framer: packs payload, captures CRC trailer, fires the crc block, reports verdict.
// Optional inter-byte gap timeout is compiled in with `define PKT_TIMEOUT_EN.
module pkt_framer
  import pkt_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = PKT_DATA_W / 8,
  parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input logic         clk,
  input logic         rst_n,
  pkt_framer_if.slave bus
);

  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);

  state_e             state_q, state_d;
  logic               in_ready_c, xfer;
  logic               pay_shift, pay_last, pay_clr;
  logic [CNT_W-1:0]   pay_cnt;
  logic [1:0]         trl_cnt_q;
  logic [CRC_W-1:0]   rx_crc_q, res_q;
  logic               crc_valid_q;
  logic [15:0]        err_cnt_q;
  logic               pkt_done_c, pkt_ok_c;
  logic               timeout, to_fail;

  assign in_ready_c = (state_q == IDLE) || (state_q == PAYLOAD) || (state_q == TRAILER);
  assign xfer       = bus.in_valid && in_ready_c;
  assign pay_shift  = (state_q == PAYLOAD) && xfer;
  assign pay_last   = pay_shift && (pay_cnt == CNT_W'(PAYLOAD_BYTES - 1));
  assign pay_clr    = (state_q != PAYLOAD) || pay_last;

  pkt_shift_reg #(.N_BYTES(PAYLOAD_BYTES)) u_payload (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (pay_clr),
    .shift_i (pay_shift),
    .byte_i  (bus.in_data),
    .data_o  (bus.crc_data),
    .cnt_o   (pay_cnt)
  );

`ifdef PKT_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_q;
  logic             to_q, in_body;

  assign in_body = (state_q == PAYLOAD) || (state_q == TRAILER);
  assign timeout = in_body && !xfer && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
  assign to_fail = to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
      to_q  <= 1'b0;
    end else begin
      gap_q <= (in_body && !xfer) ? gap_q + 1'b1 : '0;
      to_q  <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign to_fail = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (xfer && bus.in_data == SOF_BYTE) state_d = PAYLOAD;
      PAYLOAD:  if (pay_last) state_d = TRAILER;
      TRAILER:  if (xfer && trl_cnt_q == 2'd3) state_d = CRC_WAIT;
      CRC_WAIT: if (bus.crc_done) state_d = REPORT;
      REPORT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A timed-out packet reuses the REPORT cycle to emit its failing verdict.
    if (timeout) state_d = REPORT;
  end

  assign pkt_done_c = (state_q == REPORT);
  assign pkt_ok_c   = pkt_done_c && !to_fail && (res_q == rx_crc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      trl_cnt_q   <= '0;
      rx_crc_q    <= '0;
      res_q       <= '0;
      crc_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_valid_q <= (state_q == TRAILER) && xfer && (trl_cnt_q == 2'd3);
      if ((state_q == TRAILER) && xfer) begin
        rx_crc_q  <= {rx_crc_q[CRC_W-9:0], bus.in_data};
        trl_cnt_q <= trl_cnt_q + 1'b1;
      end else if (state_q != TRAILER) begin
        trl_cnt_q <= '0;
      end
      if ((state_q == CRC_WAIT) && bus.crc_done) res_q <= bus.crc_result;
      if (pkt_done_c && !pkt_ok_c && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.crc_valid = crc_valid_q;
  assign bus.pkt_done  = pkt_done_c;
  assign bus.pkt_ok    = pkt_ok_c;
  assign bus.rx_crc    = rx_crc_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer with a behavioural crc block that answers
// 32'h639A9721 only when it sees the reference payload vector.
module tb_pkt_framer;
  import pkt_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkt_framer_if bus ();

  pkt_framer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam logic [31:0] GOOD_CRC = 32'h639A9721;

  logic [PKT_DATA_W-1:0] exp_vec;
  int n_chk  = 0;
  int n_fail = 0;

  int          done_cnt = 0, ok_cnt = 0, crc_vld_cnt = 0, ok_leak = 0;
  logic        last_ok;
  logic [31:0] last_rx;
  int          stray_req = 0;

  typedef struct {
    bit          garbage;
    bit          gappy;
    logic [31:0] trailer;
    bit          exp_ok;
    logic [15:0] exp_err;
  } vec_t;

  function automatic logic [7:0] pay_byte(int k);
    logic [63:0] head;
    head = 64'h0123456789ABCDEF;
    if (k < 8)   return head[63-8*k -: 8];
    if (k >= 32) return head[63-8*(k-32) -: 8];
    if (k == 20) return 8'h7E;
    return 8'((k - 8) * 17);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // crc block model: answers two cycles after the start pulse
  initial begin
    int stray_seen;
    logic [31:0] r;
    stray_seen = 0;
    bus.crc_done   = 1'b0;
    bus.crc_result = '0;
    forever begin
      @(negedge clk);
      if (bus.crc_valid) begin
        r = (bus.crc_data == exp_vec) ? GOOD_CRC : 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        bus.crc_result = r;
        bus.crc_done   = 1'b1;
        @(negedge clk);
        bus.crc_done   = 1'b0;
      end else if (stray_req != stray_seen) begin
        stray_seen++;
        bus.crc_result = GOOD_CRC;
        bus.crc_done   = 1'b1;
        @(negedge clk);
        bus.crc_done   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.crc_valid) crc_vld_cnt++;
    if (bus.pkt_done) begin
      done_cnt++;
      last_ok = bus.pkt_ok;
      last_rx = bus.rx_crc;
      if (bus.pkt_ok) ok_cnt++;
    end else if (bus.pkt_ok) begin
      ok_leak++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int n;
    if (gappy) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send_pkt(input bit garbage, input bit gappy, input logic [31:0] trl);
    logic [7:0] g[3];
    g = '{8'h00, 8'hFF, 8'h55};
    if (garbage) for (int i = 0; i < 3; i++) send_byte(g[i], gappy);
    send_byte(8'h7E, gappy);
    for (int k = 0; k < 40; k++) send_byte(pay_byte(k), gappy);
    for (int i = 0; i < 4; i++) send_byte(trl[31-8*i -: 8], gappy);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) chk("pkt_done_timeout", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    vec_t vecs[5];
    int d0, v0, o0, n;

    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int d0, v0, o0, n;

    for (int k = 0; k < 40; k++) exp_vec[PKT_DATA_W-1-8*k -: 8] = pay_byte(k);

    vecs[0] = '{garbage:0, gappy:0, trailer:32'h639A9721, exp_ok:1, exp_err:16'd0};
    vecs[1] = '{garbage:0, gappy:0, trailer:32'h639A9720, exp_ok:0, exp_err:16'd1};
    vecs[2] = '{garbage:1, gappy:0, trailer:32'h639A9721, exp_ok:1, exp_err:16'd1};
    vecs[3] = '{garbage:1, gappy:1, trailer:32'h639A9721, exp_ok:1, exp_err:16'd1};
    vecs[4] = '{garbage:0, gappy:1, trailer:32'h12345678, exp_ok:0, exp_err:16'd2};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_crc_valid", 32'(bus.crc_valid), 32'd0);
    chk("rst_crc_data",  32'(bus.crc_data == '0), 32'd1);
    chk("rst_pkt_done",  32'(bus.pkt_done), 32'd0);
    chk("rst_pkt_ok",    32'(bus.pkt_ok), 32'd0);
    chk("rst_rx_crc",    bus.rx_crc, 32'd0);
    chk("rst_err_cnt",   32'(bus.err_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      v0 = crc_vld_cnt;
      send_pkt(vecs[i].garbage, vecs[i].gappy, vecs[i].trailer);
      wait_done(d0 + 1, 40);
      chk($sformatf("v%0d_crc_valid_pulses", i), 32'(crc_vld_cnt - v0), 32'd1);
      chk($sformatf("v%0d_pkt_ok", i), 32'(last_ok), 32'(vecs[i].exp_ok));
      chk($sformatf("v%0d_rx_crc", i), last_rx, vecs[i].trailer);
      chk($sformatf("v%0d_crc_data", i), 32'(bus.crc_data == exp_vec), 32'd1);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_err_cnt", i), 32'(bus.err_cnt), 32'(vecs[i].exp_err));
    end

    // Stray crc_done outside CRC_WAIT must not produce a verdict
    d0 = done_cnt;
    stray_req++;
    repeat (6) @(negedge clk);
    chk("stray_done_ignored", 32'(done_cnt - d0), 32'd0);

    // Back-to-back packets: second one is held off during CRC_WAIT
    d0 = done_cnt;
    o0 = ok_cnt;
    send_pkt(0, 0, GOOD_CRC);
    @(negedge clk);
    chk("ready_low_in_crc_wait", 32'(bus.in_ready), 32'd0);
    send_pkt(0, 0, GOOD_CRC);
    wait_done(d0 + 2, 40);
    chk("b2b_verdicts", 32'(done_cnt - d0), 32'd2);
    chk("b2b_ok_count", 32'(ok_cnt - o0), 32'd2);

    // Reset in the middle of the payload
    send_byte(8'h7E, 0);
    for (int k = 0; k < 20; k++) send_byte(pay_byte(k), 0);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_crc_data", 32'(bus.crc_data == '0), 32'd1);
    chk("mid_rst_err_cnt",  32'(bus.err_cnt), 32'd0);
    chk("mid_rst_rx_crc",   bus.rx_crc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_verdict", 32'(done_cnt - d0), 32'd0);
    send_pkt(0, 0, GOOD_CRC);
    wait_done(d0 + 1, 40);
    chk("post_rst_pkt_ok", 32'(last_ok), 32'd1);

    // Long stall after 10 payload bytes
    d0 = done_cnt;
    v0 = crc_vld_cnt;
    send_byte(8'h7E, 0);
    for (int k = 0; k < 10; k++) send_byte(pay_byte(k), 0);
`ifdef PKT_TIMEOUT_EN
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_verdict", 32'(done_cnt - d0), 32'd1);
    chk("to_not_early", 32'(n >= 250 && n <= 262), 32'd1);
    chk("to_pkt_ok", 32'(last_ok), 32'd0);
    chk("to_no_crc_valid", 32'(crc_vld_cnt - v0), 32'd0);
    @(negedge clk);
    chk("to_back_idle", 32'(bus.in_ready), 32'd1);
    chk("to_err_cnt", 32'(bus.err_cnt), 32'd1);
`else
    repeat (300) @(negedge clk);
    chk("stall_no_verdict", 32'(done_cnt - d0), 32'd0);
    for (int k = 10; k < 40; k++) send_byte(pay_byte(k), 0);
    for (int i = 0; i < 4; i++) send_byte(GOOD_CRC[31-8*i -: 8], 0);
    wait_done(d0 + 1, 40);
    chk("stall_pkt_ok", 32'(last_ok), 32'd1);
    chk("stall_crc_valid", 32'(crc_vld_cnt - v0), 32'd1);
`endif

    chk("pkt_ok_only_with_done", 32'(ok_leak), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
